// File: rtl/ahb_lite_master.sv
// ----------------------------------------------------------------------------
// ahb_lite_master
//
// Single-outstanding AHB-Lite initiator. Takes one read/write request at a
// time from a core-side valid/ready port. Each request goes out on the bus as
// one NONSEQ single transfer. Slave wait states are absorbed here, and the
// result comes back on a one-cycle response strobe.
//
// Optional feature: define BUS_TIMEOUT_EN to bound the data phase. When it is
// defined, TIMEOUT consecutive HREADY-low cycles in the data phase force an
// error completion. When it is undefined, the data phase waits for HREADY
// indefinitely and the TIMEOUT parameter does not exist.
//
// Ports:
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   req_valid/req_ready  core request handshake (ready only while idle)
//   req_write            1 = write, 0 = read
//   req_size             0 = byte, 1 = halfword, 2 = word, 3 = illegal
//   req_addr, req_wdata  byte address and write data
//   rsp_valid            one-cycle completion strobe
//   rsp_rdata            read data (0 for writes and errors), held until next rsp
//   rsp_err              transfer failed (bus ERROR, misaligned/illegal, timeout)
//   HADDR, HTRANS, HWRITE, HSIZE, HWDATA   registered AHB master outputs
//   HRDATA, HREADY, HRESP                  AHB slave-side inputs
// ----------------------------------------------------------------------------
module ahb_lite_master
`ifdef BUS_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT = 16
)
`endif
(
  input  logic        HCLK,
  input  logic        HRESETn,

  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,

  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,

  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAddr = 2'd1;
  localparam logic [1:0] StData = 2'd2;

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;

  logic [1:0]  state_q, state_d;
  logic [31:0] haddr_q, haddr_d;
  logic [1:0]  htrans_q, htrans_d;
  logic        hwrite_q, hwrite_d;
  logic [2:0]  hsize_q, hsize_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        req_illegal;

`ifdef BUS_TIMEOUT_EN
  logic [4:0]  wait_cnt_q, wait_cnt_d;
`endif

  // A request is rejected without touching the bus when its size is the
  // reserved encoding or its address is not naturally aligned to that size.
  always_comb begin
    req_illegal = 1'b0;
    unique case (req_size)
      2'd0:    req_illegal = 1'b0;
      2'd1:    req_illegal = req_addr[0];
      2'd2:    req_illegal = |req_addr[1:0];
      default: req_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    haddr_d     = haddr_q;
    htrans_d    = htrans_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    hwdata_d    = hwdata_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef BUS_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_illegal) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else begin
            haddr_d  = req_addr;
            hwrite_d = req_write;
            hsize_d  = {1'b0, req_size};
            htrans_d = TransNonseq;
            wdata_d  = req_wdata;
            state_d  = StAddr;
          end
        end
      end

      // Address phase: the control signals stay put until the slave side
      // signals HREADY, which accepts the address.
      StAddr: begin
        if (HREADY) begin
          htrans_d = TransIdle;
          hwdata_d = wdata_q;
          state_d  = StData;
`ifdef BUS_TIMEOUT_EN
          wait_cnt_d = 5'd0;
`endif
        end
      end

      // Data phase: HRESP with HREADY low is the first half of a two-cycle
      // error and is simply waited through; only the HREADY-high edge counts.
      StData: begin
        if (HREADY) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = HRESP;
          rsp_rdata_d = (!hwrite_q && !HRESP) ? HRDATA : 32'h0;
          state_d     = StIdle;
`ifdef BUS_TIMEOUT_EN
        end else if (wait_cnt_q == 5'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th consecutive stalled cycle: give up.
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0;
          state_d     = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + 5'd1;
`endif
        end
      end

      default: begin
        state_d  = StIdle;
        htrans_d = TransIdle;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= StIdle;
      haddr_q     <= 32'h0;
      htrans_q    <= TransIdle;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'd0;
      hwdata_q    <= 32'h0;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hwdata_q    <= hwdata_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wait_cnt_q <= 5'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

  // The ready output is a decode of registered state, so the next request
  // can be taken in the same cycle that the response strobe is high.
  assign req_ready = (state_q == StIdle);

  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HWDATA    = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed and randomized bench for ahb_lite_master. A transaction-level
// model predicts each bus phase and response from the request, the slave wait
// plan and the slave response kind.
module tb_ahb_lite_master;

  logic        HCLK;
  logic        HRESETn;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  int checks = 0;
  int errors = 0;

  // Response values the core should currently see (held between strobes).
  logic [31:0] last_rdata;
  logic        last_err;

`ifdef BUS_TIMEOUT_EN
  localparam int TimeoutCycles = 16;
`endif

  ahb_lite_master dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk_idle();
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("idle_htrans", HTRANS, 0);
    chk("idle_req_ready", req_ready, 1);
    chk("idle_rsp_rdata_hold", rsp_rdata, last_rdata);
    chk("idle_rsp_err_hold", rsp_err, last_err);
  endtask

  // ek: 0 = OKAY, 1 = single-cycle ERROR, 2 = two-cycle ERROR (needs dw >= 1)
  task automatic run_txn(input logic wr, input logic [1:0] sz, input logic [31:0] ad,
                         input logic [31:0] wd, input int aw, input int dw,
                         input int ek, input logic [31:0] rd);
    logic        illegal;
    logic        err;
    logic [31:0] exp_rd;
    illegal = (sz == 2'd3) || ((ad % (32'd1 << sz)) != 32'd0);
    chk("req_ready_before", req_ready, 1);
    req_valid = 1'b1;
    req_write = wr;
    req_size  = sz;
    req_addr  = ad;
    req_wdata = wd;
    HREADY    = 1'b1;
    HRESP     = 1'b0;
    step();
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_size  = 2'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;

    if (illegal) begin
      last_rdata = 32'h0;
      last_err   = 1'b1;
      chk("bad_rsp_valid", rsp_valid, 1);
      chk("bad_rsp_err", rsp_err, 1);
      chk("bad_rsp_rdata", rsp_rdata, 0);
      chk("bad_htrans", HTRANS, 0);
      chk("bad_req_ready", req_ready, 1);
      return;
    end

    for (int i = 0; i <= aw; i++) begin
      chk("addr_htrans", HTRANS, 2);
      chk("addr_haddr", HADDR, ad);
      chk("addr_hwrite", HWRITE, wr);
      chk("addr_hsize", HSIZE, {1'b0, sz});
      chk("addr_rsp_valid", rsp_valid, 0);
      chk("addr_req_ready", req_ready, 0);
      chk("addr_rsp_rdata_hold", rsp_rdata, last_rdata);
      chk("addr_rsp_err_hold", rsp_err, last_err);
      HREADY = (i == aw);
      HRDATA = $urandom;
      step();
    end

    for (int i = 0; i <= dw; i++) begin
      chk("data_htrans", HTRANS, 0);
      chk("data_hwdata", HWDATA, wd);
      chk("data_rsp_valid", rsp_valid, 0);
      chk("data_req_ready", req_ready, 0);
      if (i < dw) begin
        HREADY = 1'b0;
        HRESP  = (ek == 2) && (i == dw - 1);
        HRDATA = $urandom;
      end else begin
        HREADY = 1'b1;
        HRESP  = (ek != 0);
        HRDATA = rd;
      end
      step();
`ifdef BUS_TIMEOUT_EN
      if (i < dw && i == TimeoutCycles - 1) begin
        last_rdata = 32'h0;
        last_err   = 1'b1;
        chk("tmo_rsp_valid", rsp_valid, 1);
        chk("tmo_rsp_err", rsp_err, 1);
        chk("tmo_rsp_rdata", rsp_rdata, 0);
        chk("tmo_req_ready", req_ready, 1);
        HREADY = 1'b1;
        HRESP  = 1'b0;
        return;
      end
`endif
    end

    err        = (ek != 0);
    exp_rd     = (!wr && !err) ? rd : 32'h0;
    last_rdata = exp_rd;
    last_err   = err;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_err", rsp_err, err);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_req_ready", req_ready, 1);
    chk("rsp_htrans", HTRANS, 0);
    HRESP  = 1'b0;
    HRDATA = $urandom;
  endtask

  initial begin
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] ad;
    int          aw;
    int          dw;
    int          ek;

    HRESETn   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size  = 2'd0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    HRDATA    = 32'h0;
    HREADY    = 1'b1;
    HRESP     = 1'b0;
    last_rdata = 32'h0;
    last_err   = 1'b0;

    repeat (2) step();
    chk("rst_htrans", HTRANS, 0);
    chk("rst_haddr", HADDR, 0);
    chk("rst_hwrite", HWRITE, 0);
    chk("rst_hsize", HSIZE, 0);
    chk("rst_hwdata", HWDATA, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    #2 HRESETn = 1'b1;
    step();
    chk_idle();

    // Zero-wait word write, then 3-wait-state word read of the same location.
    run_txn(1'b1, 2'd2, 32'h100, 32'hDEADBEEF, 0, 0, 0, 32'h0);
    step();
    chk_idle();
    run_txn(1'b0, 2'd2, 32'h100, 32'h0, 0, 3, 0, 32'hDEADBEEF);
    // Misaligned halfword read is rejected without a bus transfer.
    run_txn(1'b0, 2'd1, 32'h103, 32'h0, 0, 0, 0, 32'h0);
    step();
    chk_idle();
    // Single-cycle ERROR, then an OKAY read back-to-back.
    run_txn(1'b0, 2'd2, 32'h4000, 32'h0, 0, 0, 1, 32'h12345678);
    run_txn(1'b0, 2'd2, 32'h100, 32'h0, 0, 0, 0, 32'hDEADBEEF);
    // Two-cycle ERROR with address-phase stalls; illegal size 3.
    run_txn(1'b1, 2'd0, 32'h7, 32'hA5A5A5A5, 2, 2, 2, 32'h0);
    run_txn(1'b1, 2'd3, 32'h0, 32'h1, 0, 0, 0, 32'h0);

    // Reset asserted in the middle of a read data phase.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = 2'd2;
    req_addr  = 32'h200;
    req_wdata = 32'h55AA55AA;
    HREADY    = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    chk("prerst_htrans", HTRANS, 0);
    HREADY = 1'b0;
    step();
    #2 HRESETn = 1'b0;
    #1;
    chk("midrst_htrans", HTRANS, 0);
    chk("midrst_haddr", HADDR, 0);
    chk("midrst_hwdata", HWDATA, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_req_ready", req_ready, 1);
    HREADY = 1'b1;
    step();
    chk("midrst_rsp_valid2", rsp_valid, 0);
    last_rdata = 32'h0;
    last_err   = 1'b0;
    #2 HRESETn = 1'b1;
    step();
    chk_idle();
    run_txn(1'b0, 2'd2, 32'h100, 32'h0, 0, 1, 0, 32'hCAFEF00D);

    // Long stall: waits indefinitely, or times out after 16 cycles.
    run_txn(1'b0, 2'd2, 32'h300, 32'h0, 0, 20, 0, 32'h0BADF00D);
    step();
    chk_idle();

    for (int n = 0; n < 60; n++) begin
      wr = 1'($urandom);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ad = $urandom;
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) ad = ad & ~((32'd1 << sz) - 32'd1);
      aw = $urandom_range(0, 2);
      dw = $urandom_range(0, 4);
      ek = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
      if (ek == 2 && dw == 0) dw = 1;
      run_txn(wr, sz, ad, $urandom, aw, dw, ek, $urandom);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        step();
        chk_idle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
